// File: rtl/dc_motor_pkg.sv
// dc_motor_pkg: shared definitions for the Wishbone DC motor PWM block.
// Holds the register word indices, CTRL bit positions, the per-channel
// FSM state type and small helpers for address decode and byte merging.
package dc_motor_pkg;

    // Word indices (byte address bits [5:2])
    localparam logic [3:0] WORD_PRESCALE = 4'd0;
    localparam logic [3:0] WORD_STATUS   = 4'd1;
    localparam logic [3:0] WORD_CH_BASE  = 4'd2;

    // CTRL register layout
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIR_BIT = 1;
    localparam int CTRL_W       = 2;

    // Per-channel FSM state (kept as plain constants for legacy tools)
    typedef logic [0:0] ch_state_t;
    localparam ch_state_t ST_RUN     = 1'b0;
    localparam ch_state_t ST_REVERSE = 1'b1;

    // Word index of channel ch's CTRL register
    function automatic logic [3:0] ctrl_word(input int ch);
        return WORD_CH_BASE + 4'(2 * ch);
    endfunction

    // Word index of channel ch's DUTY register
    function automatic logic [3:0] duty_word(input int ch);
        return WORD_CH_BASE + 4'(2 * ch + 1);
    endfunction

    // Replace the bytes of old_word selected by sel with those of new_word
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dc_motor_pwm_wb_channel.sv
// dc_motor_channel: one motor channel -- soft duty ramp, RUN/REVERSE
// direction FSM and PWM compare against the shared period counter.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   en_i, dir_req_i    CTRL.enable and CTRL.dir of this channel
//   duty_tgt_i         DUTY register (ramp target while in RUN)
//   period_cnt_i       shared period counter
//   period_end_i       one-clock strobe when the period counter wraps
//   pwm_o, dir_o       registered PMOD drive
//   busy_o             ramp or reversal still in progress
module dc_motor_channel
    import dc_motor_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             dir_req_i,
    input  logic [PWM_W-1:0] duty_tgt_i,
    input  logic [PWM_W-1:0] period_cnt_i,
    input  logic             period_end_i,
    output logic             pwm_o,
    output logic             dir_o,
    output logic             busy_o
);

    localparam logic [PWM_W-1:0] DUTY_ZERO = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] DUTY_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};

    ch_state_t        state_q, state_d;
    logic [PWM_W-1:0] cur_q, cur_d;
    logic             dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic [PWM_W-1:0] eff_tgt_s;

    // Reversal first ramps the motor to standstill before flipping direction
    always_comb begin
        if (state_q == ST_REVERSE) begin
            eff_tgt_s = DUTY_ZERO;
        end else begin
            eff_tgt_s = duty_tgt_i;
        end
    end

    // Ramp stepping and direction FSM next state
    always_comb begin
        cur_d   = cur_q;
        state_d = state_q;
        dir_d   = dir_q;
        if (!en_i) begin
            // Disabled channel: stop at once and let direction follow CTRL
            cur_d   = DUTY_ZERO;
            state_d = ST_RUN;
            dir_d   = dir_req_i;
        end else begin
            if (period_end_i && (cur_q < eff_tgt_s)) begin
                cur_d = cur_q + DUTY_ONE;
            end else if (period_end_i && (cur_q > eff_tgt_s)) begin
                cur_d = cur_q - DUTY_ONE;
            end else begin
                cur_d = cur_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (dir_req_i != dir_q) begin
                        state_d = ST_REVERSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_REVERSE: begin
                    if (dir_req_i == dir_q) begin
                        // Request withdrawn before standstill: keep direction
                        state_d = ST_RUN;
                    end else if (period_end_i && (cur_q == DUTY_ZERO)) begin
                        dir_d   = dir_req_i;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_REVERSE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // PWM compare; duty of all ones stays high because the counter stops one short
    always_comb begin
        pwm_d = en_i && (period_cnt_i < cur_q);
    end

    // Channel state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            cur_q   <= DUTY_ZERO;
            dir_q   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign dir_o  = dir_q;
    assign busy_o = (cur_q != eff_tgt_s) || (state_q == ST_REVERSE);

endmodule

// File: rtl/dc_motor_pwm_wb.sv
// dc_motor_pwm_wb: Wishbone-controlled multi-channel DC motor PWM driver.
// Holds the register file, global prescaler, shared period counter and
// instantiates one dc_motor_channel per motor.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_wb_adr/dat/sel/we/cyc/stb, o_wb_dat/ack   Wishbone slave (1 wait state)
//   o_pwm[NUM_CH], o_dir[NUM_CH]                PMOD drive per channel
module dc_motor_pwm_wb
    import dc_motor_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PWM_W  = 8,
    parameter int PRE_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [5:0]        i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic [NUM_CH-1:0] o_pwm,
    output logic [NUM_CH-1:0] o_dir
);

    // Last counter value before wrap: period is 2^PWM_W-1 ticks
    localparam logic [PWM_W-1:0] PER_LAST =
        {PWM_W{1'b1}} - {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PER_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0]                   prescale_q, prescale_d;
    logic [PRE_W-1:0]                   presc_cnt_q, presc_cnt_d;
    logic [PWM_W-1:0]                   period_cnt_q, period_cnt_d;
    logic [NUM_CH-1:0][CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic [NUM_CH-1:0][PWM_W-1:0]       duty_q, duty_d;
    logic                               ack_q, ack_d;
    logic [31:0]                        rdat_q, rdat_d;

    logic                               req_s;
    logic                               wr_s;
    logic [3:0]                         word_s;
    logic [31:0]                        rd_word_s;
    logic [31:0]                        wr_word_s;
    logic                               presc_restart_s;
    logic                               tick_s;
    logic                               period_end_s;
    logic [NUM_CH-1:0]                  busy_s;
    logic                               unused_s;

    assign req_s    = i_wb_cyc && i_wb_stb && !ack_q;
    assign wr_s     = req_s && i_wb_we;
    assign word_s   = i_wb_adr[5:2];
    assign unused_s = ^{i_wb_adr[1:0], wr_word_s};

    // Read mux; unmapped words and absent channels decode to zero
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (word_s == WORD_PRESCALE) begin
            rd_word_s = 32'(prescale_q);
        end else if (word_s == WORD_STATUS) begin
            rd_word_s = 32'(busy_s);
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (word_s == ctrl_word(n)) begin
                    rd_word_s = 32'(ctrl_q[n]);
                end else if (word_s == duty_word(n)) begin
                    rd_word_s = 32'(duty_q[n]);
                end else begin
                    rd_word_s = rd_word_s;
                end
            end
        end
    end

    // Register writes: merge enabled bytes into the addressed word's current value
    always_comb begin
        wr_word_s       = byte_merge(rd_word_s, i_wb_dat, i_wb_sel);
        prescale_d      = prescale_q;
        ctrl_d          = ctrl_q;
        duty_d          = duty_q;
        presc_restart_s = 1'b0;
        if (wr_s && (word_s == WORD_PRESCALE)) begin
            prescale_d      = wr_word_s[PRE_W-1:0];
            presc_restart_s = 1'b1;
        end else if (wr_s) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (word_s == ctrl_word(n)) begin
                    ctrl_d[n] = wr_word_s[CTRL_W-1:0];
                end else if (word_s == duty_word(n)) begin
                    duty_d[n] = wr_word_s[PWM_W-1:0];
                end else begin
                    duty_d[n] = duty_d[n];
                end
            end
        end else begin
            presc_restart_s = 1'b0;
        end
    end

    // Prescaler: tick when the count reaches PRESCALE, restart on PRESCALE write
    always_comb begin
        tick_s      = 1'b0;
        presc_cnt_d = presc_cnt_q;
        if (presc_restart_s) begin
            presc_cnt_d = {PRE_W{1'b0}};
        end else if (presc_cnt_q >= prescale_q) begin
            tick_s      = 1'b1;
            presc_cnt_d = {PRE_W{1'b0}};
        end else begin
            presc_cnt_d = presc_cnt_q + PRE_ONE;
        end
    end

    // Shared period counter and period-end strobe
    always_comb begin
        period_end_s = tick_s && (period_cnt_q == PER_LAST);
        if (period_end_s) begin
            period_cnt_d = {PWM_W{1'b0}};
        end else if (tick_s) begin
            period_cnt_d = period_cnt_q + PER_ONE;
        end else begin
            period_cnt_d = period_cnt_q;
        end
    end

    // Single-cycle ack; read data captured alongside it
    always_comb begin
        ack_d = req_s;
        if (req_s) begin
            rdat_d = rd_word_s;
        end else begin
            rdat_d = 32'h0000_0000;
        end
    end

    // Top-level state registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prescale_q   <= {PRE_W{1'b0}};
            presc_cnt_q  <= {PRE_W{1'b0}};
            period_cnt_q <= {PWM_W{1'b0}};
            ctrl_q       <= {(NUM_CH*CTRL_W){1'b0}};
            duty_q       <= {(NUM_CH*PWM_W){1'b0}};
            ack_q        <= 1'b0;
            rdat_q       <= 32'h0000_0000;
        end else begin
            prescale_q   <= prescale_d;
            presc_cnt_q  <= presc_cnt_d;
            period_cnt_q <= period_cnt_d;
            ctrl_q       <= ctrl_d;
            duty_q       <= duty_d;
            ack_q        <= ack_d;
            rdat_q       <= rdat_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        dc_motor_channel #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk_i        (i_clk),
            .rst_ni       (i_rst_n),
            .en_i         (ctrl_q[n][CTRL_EN_BIT]),
            .dir_req_i    (ctrl_q[n][CTRL_DIR_BIT]),
            .duty_tgt_i   (duty_q[n]),
            .period_cnt_i (period_cnt_q),
            .period_end_i (period_end_s),
            .pwm_o        (o_pwm[n]),
            .dir_o        (o_dir[n]),
            .busy_o       (busy_s[n])
        );
    end

    assign o_wb_ack = ack_q;
    assign o_wb_dat = rdat_q;

endmodule

// File: tb/tb_dc_motor_pwm_wb.sv
// tb_dc_motor_pwm_wb: self-checking bench for dc_motor_pwm_wb.
// Uses a 6-bit PWM so full-scale ramps stay short (period = 63 ticks).
module tb_dc_motor_pwm_wb;

    localparam int NUM_CH = 2;
    localparam int PWM_W  = 6;
    localparam int PRE_W  = 16;
    localparam int PERIOD = (1 << PWM_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        wb_adr;
    logic [31:0]       wb_wdat;
    logic [3:0]        wb_sel;
    logic              wb_we, wb_cyc, wb_stb;
    logic [31:0]       wb_rdat;
    logic              wb_ack;
    logic [NUM_CH-1:0] pwm, dir;

    int total = 0;
    int bad   = 0;

    // Reference register file
    logic [31:0] m_presc;
    logic [31:0] m_ctrl [NUM_CH];
    logic [31:0] m_duty [NUM_CH];

    always #5 clk = ~clk;

    dc_motor_pwm_wb #(.NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRE_W(PRE_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(wb_adr), .i_wb_dat(wb_wdat),
        .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
        .o_wb_dat(wb_rdat), .o_wb_ack(wb_ack), .o_pwm(pwm), .o_dir(dir)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel, input int width);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        if (width < 32) r = r & ((32'd1 << width) - 32'd1);
        return r;
    endfunction

    task automatic model_write(input int word, input logic [31:0] d, input logic [3:0] s);
        if (word == 0) m_presc = merge(m_presc, d, s, PRE_W);
        else if (word >= 2 && word < 2 + 2*NUM_CH) begin
            if (word % 2 == 0) m_ctrl[(word-2)/2] = merge(m_ctrl[(word-2)/2], d, s, 2);
            else               m_duty[(word-2)/2] = merge(m_duty[(word-2)/2], d, s, PWM_W);
        end
    endtask

    function automatic logic [31:0] model_read(input int word);
        if (word == 0) return m_presc;
        if (word >= 2 && word < 2 + 2*NUM_CH)
            return (word % 2 == 0) ? m_ctrl[(word-2)/2] : m_duty[(word-2)/2];
        return 32'h0;
    endfunction

    task automatic model_clear();
        m_presc = 32'h0;
        for (int n = 0; n < NUM_CH; n++) begin m_ctrl[n] = 32'h0; m_duty[n] = 32'h0; end
    endtask

    // One Wishbone transfer with a bounded wait for ack
    task automatic wb_cycle(input logic we, input int word, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 32'h0;
        @(negedge clk);
        wb_adr = {4'(word), 2'b00}; wb_wdat = d; wb_sel = s; wb_we = we;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin got = 1'b1; rd = wb_rdat; end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL wb_ack_timeout word=%0d got=no_ack want=ack", word); end
    endtask

    task automatic wb_write(input int word, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_cycle(1'b1, word, d, s, dummy);
        model_write(word, d, s);
    endtask

    task automatic wb_read(input int word, output logic [31:0] rd);
        wb_cycle(1'b0, word, 32'h0, 4'hF, rd);
    endtask

    task automatic count_high(input int ch, input int nclk, output int n);
        n = 0;
        for (int i = 0; i < nclk; i++) begin @(posedge clk); #1; if (pwm[ch]) n++; end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = 6'h0; wb_wdat = 32'h0; wb_sel = 4'h0;
        repeat (3) @(posedge clk); #1;
        total++; if (pwm !== 2'b00) begin bad++; $display("FAIL reset_pwm got=%0h want=0", pwm); end
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%0h want=0", dir); end
        total++; if (wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b want=0", wb_ack); end
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        for (int w = 0; w < 16; w++) begin
            wb_read(w, rd);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_word%0d got=%0h want=0", w, rd); end
        end
    endtask

    task automatic test_registers();
        int w; logic [31:0] d; logic [3:0] s; logic [31:0] rd;
        for (int k = 0; k < 30; k++) begin
            w = int'($urandom_range(0, 15));
            d = $urandom();
            s = 4'($urandom_range(0, 15));
            wb_write(w, d, s);
            if (w != 1) begin
                wb_read(w, rd);
                total++;
                if (rd !== model_read(w)) begin
                    bad++; $display("FAIL reg_rw word=%0d got=%0h want=%0h", w, rd, model_read(w));
                end
            end
        end
        for (int n = 0; n < NUM_CH; n++) begin
            wb_write(2 + 2*n, 32'h0, 4'hF);
            wb_write(3 + 2*n, 32'h0, 4'hF);
        end
        wb_write(0, 32'h0, 4'hF);
    endtask

    task automatic test_duty_ramp();
        int p, d, prev, per, n, steps; logic [31:0] rd;
        wb_write(3, 32'h0, 4'hF);
        wb_write(2, 32'h1, 4'hF);
        count_high(0, 2*PERIOD, n);
        total++; if (n != 0) begin bad++; $display("FAIL duty_zero_low got=%0d want=0", n); end
        prev = 0;
        for (int it = 0; it < 3; it++) begin
            p = int'($urandom_range(0, 2));
            d = int'($urandom_range(1, 20));
            if (d == prev) d = prev + 1;
            wb_write(0, 32'(p), 4'hF);
            wb_write(3, 32'(d), 4'hF);
            wb_read(1, rd);
            total++; if (rd[0] !== 1'b1) begin bad++; $display("FAIL ramp_busy got=%0h want=bit0", rd); end
            per   = (p + 1) * PERIOD;
            steps = (d > prev) ? d - prev : prev - d;
            repeat ((steps + 2) * per) @(posedge clk);
            count_high(0, per, n);
            total++;
            if (n != d*(p+1)) begin bad++; $display("FAIL ramp_high p=%0d d=%0d got=%0d want=%0d", p, d, n, d*(p+1)); end
            wb_read(1, rd);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL ramp_idle got=%0h want=0", rd); end
            prev = d;
        end
        wb_write(0, 32'h0, 4'hF);
    endtask

    task automatic test_reverse();
        int n, since, elapsed; bit found; logic [31:0] rd;
        wb_write(3, 32'd3, 4'hF);
        repeat (22*PERIOD) @(posedge clk);
        #1;
        total++; if (dir[0] !== 1'b0) begin bad++; $display("FAIL rev_dir_before got=%0b want=0", dir[0]); end
        wb_write(2, 32'd3, 4'hF);
        wb_read(1, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL rev_busy got=%0h want=1", rd); end
        found = 1'b0; since = 0; elapsed = 0;
        for (int i = 0; i < 6*PERIOD && !found; i++) begin
            @(posedge clk); #1;
            elapsed++;
            if (dir[0]) found = 1'b1;
            else if (pwm[0]) since = 0;
            else since++;
        end
        total++; if (!found) begin bad++; $display("FAIL rev_toggle got=no_toggle want=toggle"); end
        total++; if (since < PERIOD) begin bad++; $display("FAIL rev_zero_period got=%0d want>=%0d", since, PERIOD); end
        total++; if (elapsed < 2*PERIOD) begin bad++; $display("FAIL rev_early got=%0d want>=%0d", elapsed, 2*PERIOD); end
        repeat (5*PERIOD) @(posedge clk);
        count_high(0, PERIOD, n);
        total++; if (n != 3) begin bad++; $display("FAIL rev_ramp_back got=%0d want=3", n); end
        wb_read(1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rev_idle got=%0h want=0", rd); end
        // Withdraw a reversal request before standstill
        wb_write(2, 32'd1, 4'hF);
        wb_write(2, 32'd3, 4'hF);
        repeat (5*PERIOD) @(posedge clk);
        #1;
        total++; if (dir[0] !== 1'b1) begin bad++; $display("FAIL rev_restore_dir got=%0b want=1", dir[0]); end
        count_high(0, PERIOD, n);
        total++; if (n != 3) begin bad++; $display("FAIL rev_restore_duty got=%0d want=3", n); end
    endtask

    task automatic test_full_disable();
        int n; logic [31:0] rd;
        wb_write(3, 32'(PERIOD), 4'hF);
        repeat ((PERIOD + 2) * PERIOD) @(posedge clk);
        count_high(0, 3*PERIOD, n);
        total++; if (n != 3*PERIOD) begin bad++; $display("FAIL full_high got=%0d want=%0d", n, 3*PERIOD); end
        wb_write(2, 32'h0, 4'hF);
        @(posedge clk); #1;
        total++; if (pwm[0] !== 1'b0) begin bad++; $display("FAIL disable_pwm got=%0b want=0", pwm[0]); end
        total++; if (dir[0] !== 1'b0) begin bad++; $display("FAIL disable_dir got=%0b want=0", dir[0]); end
        wb_write(2, 32'h1, 4'hF);
        wb_read(1, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL disable_cleared got=%0h want=1", rd); end
        wb_write(2, 32'h0, 4'hF);
        wb_write(3, 32'h0, 4'hF);
    endtask

    task automatic test_sel_zero();
        logic [31:0] rd; logic a0, a1, a2;
        wb_write(5, 32'd5, 4'hF);
        wb_write(5, $urandom(), 4'b0000);
        wb_read(5, rd);
        total++; if (rd !== model_read(5)) begin bad++; $display("FAIL sel_zero got=%0h want=%0h", rd, model_read(5)); end
        wb_read(15, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL word15 got=%0h want=0", rd); end
        @(negedge clk);
        wb_adr = 6'h0; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b0;
        @(posedge clk); #1;
        total++; if (wb_ack !== 1'b0) begin bad++; $display("FAIL no_stb_ack got=%0b want=0", wb_ack); end
        wb_stb = 1'b1;
        @(posedge clk); #1; a0 = wb_ack;
        @(posedge clk); #1; a1 = wb_ack;
        @(posedge clk); #1; a2 = wb_ack;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        total++; if ({a0, a1, a2} !== 3'b101) begin bad++; $display("FAIL ack_pattern got=%b want=101", {a0, a1, a2}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        wb_write(3, 32'd20, 4'hF);
        wb_write(2, 32'd3, 4'hF);
        repeat (8*PERIOD) @(posedge clk);
        @(negedge clk);
        wb_adr = 6'h0; wb_wdat = $urandom(); wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (wb_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%0b want=0", wb_ack); end
        total++; if (pwm !== 2'b00) begin bad++; $display("FAIL rstmid_pwm got=%0h want=0", pwm); end
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL rstmid_dir got=%0h want=0", dir); end
        total++; if (wb_rdat !== 32'h0) begin bad++; $display("FAIL rstmid_dat got=%0h want=0", wb_rdat); end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; rst_n = 1'b1;
        model_clear();
        for (int w = 0; w < 16; w++) begin
            wb_read(w, rd);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_word%0d got=%0h want=0", w, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_duty_ramp();
        test_reverse();
        test_full_disable();
        test_sel_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
